mul16_shift_add: RTL and testbench

// - Sequential unsigned 16x16 -> 32-bit multiplier using shift-and-add, one partial product per clock.
// - Drives a 16-bit carry-lookahead adder every cycle (addend = multiplicand, augend = accumulator high half, cin = 0).
// - Consumes that adder's sum and carry-out, and sequences it over 16 iterations.
// - Valid/ready handshake on both the operand side and the result side.

---
 rtl/mul16_shift_add.sv | 185 ++++++++++++++++++
 tb/tb_mul16_shift_add.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_shift_add.sv
// rtl/mul16_shift_add.sv - sequential 16x16 shift-and-add multiplier around a 16-bit carry-lookahead adder
// Optional MUL_ZERO_BYPASS_EN: zero operands finish one cycle after accept instead of running all 16 steps.

module cla16_adder (
  input  logic [15:0] x_i,
  input  logic [15:0] y_i,
  input  logic        cin_i,
  output logic [15:0] sum_o,
  output logic        cout_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;

  always_comb begin
    g     = x_i & y_i;
    p     = x_i ^ y_i;
    c     = '0;
    grp_g = '0;
    grp_p = '0;
    grp_c = '0;

    for (int k = 0; k < 4; k++) begin
      grp_g[k] = g[4*k+3]
               | (p[4*k+3] & g[4*k+2])
               | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p[k] = &p[4*k +: 4];
    end

    // Second-level lookahead resolves every group carry-in directly from cin.
    grp_c[0] = cin_i;
    grp_c[1] = grp_g[0] | (grp_p[0] & cin_i);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin_i);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & cin_i);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin_i);

    for (int k = 0; k < 4; k++) begin
      c[4*k]   = grp_c[k];
      c[4*k+1] = g[4*k]   | (p[4*k]   & grp_c[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
               | (p[4*k+1] & p[4*k] & grp_c[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
    end
    c[16] = grp_c[4];

    sum_o  = p ^ c[15:0];
    cout_o = c[16];
  end

endmodule

module mul16_shift_add #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf16,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   acc_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic [2*WIDTH-1:0]   product_q;
  logic                 ovf16_q;

  logic [WIDTH-1:0]     add_sum;
  logic                 add_cout;

  cla16_adder u_adder (
    .x_i    (acc_q[2*WIDTH-1:WIDTH]),
    .y_i    (mcand_q),
    .cin_i  (1'b0),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // The adder carry becomes the top bit shifted in, so no product bit is ever dropped.
  always_comb begin
    acc_d = {1'b0, acc_q[2*WIDTH-1:1]};
    if (acc_q[0]) begin
      acc_d = {add_cout, add_sum, acc_q[WIDTH-1:1]};
    end
    cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      ovf16_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            mcand_q    <= a;
            acc_q      <= {{WIDTH{1'b0}}, b};
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef MUL_ZERO_BYPASS_EN
            // A zero operand jumps straight to the final count with a zero accumulator.
            if ((a == '0) || (b == '0)) begin
              acc_q <= '0;
              cnt_q <= CNT_W'(WIDTH);
            end
`endif
          end
        end

        RUN: begin
          if (cnt_q == CNT_W'(WIDTH)) begin
            state_q     <= DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            product_q   <= acc_q;
            ovf16_q     <= |acc_q[2*WIDTH-1:WIDTH];
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
          end
        end

        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf16     = ovf16_q;

endmodule

// File: tb/tb_mul16_shift_add.sv
// tb/tb_mul16_shift_add.sv - scoreboard bench for mul16_shift_add (honours MUL_ZERO_BYPASS_EN)

module tb_mul16_shift_add;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        ovf16;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  logic [32:0] sb[$];

`ifdef MUL_ZERO_BYPASS_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif

  mul16_shift_add dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .ovf16     (ovf16),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [32:0] model(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    p = 32'(x) * 32'(y);
    return {|p[31:16], p};
  endfunction

  task automatic issue(input logic [15:0] x, input logic [15:0] y);
    a        = x;
    b        = y;
    in_valid = 1'b1;
    sb.push_back(model(x, y));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
  endtask

  task automatic pop_exp(output logic [32:0] e);
    e = 33'h0;
    if (sb.size() > 0) e = sb.pop_front();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1)   $display("FAIL reset_in_ready: got %b want 1", in_ready);   else n_pass++;
    n_checks++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0)       $display("FAIL reset_busy: got %b want 0", busy);           else n_pass++;
    n_checks++; if (product !== 32'h0)   $display("FAIL reset_product: got %h want 0", product);     else n_pass++;
    n_checks++; if (ovf16 !== 1'b0)      $display("FAIL reset_ovf16: got %b want 0", ovf16);         else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat;
    logic [32:0] e;
    out_ready = 1'b1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready_idle: got %b want 1", in_ready); else n_pass++;
    issue(16'd3, 16'd5);
    n_checks++; if (busy !== 1'b1)     $display("FAIL basic_busy_run: got %b want 1", busy);         else n_pass++;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL basic_in_ready_run: got %b want 0", in_ready); else n_pass++;
    wait_valid(lat);
    n_checks++; if (lat !== 17) $display("FAIL basic_latency: got %0d want 17", lat); else n_pass++;
    pop_exp(e);
    n_checks++; if (product !== e[31:0]) $display("FAIL basic_product: got %h want %h", product, e[31:0]); else n_pass++;
    n_checks++; if (ovf16 !== e[32])     $display("FAIL basic_ovf16: got %b want %b", ovf16, e[32]);       else n_pass++;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_consume_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1)   $display("FAIL basic_consume_ready: got %b want 1", in_ready); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_max;
    int lat;
    logic [32:0] e;
    out_ready = 1'b1;
    issue(16'hFFFF, 16'hFFFF);
    wait_valid(lat);
    pop_exp(e);
    n_checks++; if (lat !== 17)          $display("FAIL max_latency: got %0d want 17", lat);                 else n_pass++;
    n_checks++; if (product !== e[31:0]) $display("FAIL max_product: got %h want %h", product, e[31:0]);   else n_pass++;
    n_checks++; if (ovf16 !== e[32])     $display("FAIL max_ovf16: got %b want %b", ovf16, e[32]);         else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    int lat;
    logic [32:0] e;
    out_ready = 1'b0;
    issue(16'h1234, 16'h0100);
    wait_valid(lat);
    pop_exp(e);
    n_checks++; if (lat !== 17) $display("FAIL bp_latency: got %0d want 17", lat); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || product !== e[31:0] || ovf16 !== e[32])
        $display("FAIL bp_hold%0d: got v=%b p=%h o=%b want v=1 p=%h o=%b", i, out_valid, product, ovf16, e[31:0], e[32]);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1)  $display("FAIL bp_release_ready: got %b want 1", in_ready);  else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_ignore_in_valid;
    int lat;
    logic [32:0] e;
    bit seen;
    out_ready = 1'b1;
    issue(16'd2, 16'd9);
    repeat (3) @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL ign_in_ready: got %b want 0", in_ready); else n_pass++;
    a = 16'd7; b = 16'd7; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    pop_exp(e);
    n_checks++; if (lat + 4 !== 17)      $display("FAIL ign_latency: got %0d want 17", lat + 4);           else n_pass++;
    n_checks++; if (product !== e[31:0]) $display("FAIL ign_product: got %h want %h", product, e[31:0]);   else n_pass++;
    seen = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL ign_no_second_result: got %b want 0", seen); else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort;
    int lat;
    logic [32:0] e;
    bit seen;
    out_ready = 1'b1;
    issue(16'd100, 16'd200);
    repeat (8) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL abort_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0)      $display("FAIL abort_busy: got %b want 0", busy);           else n_pass++;
    n_checks++; if (in_ready !== 1'b1)  $display("FAIL abort_in_ready: got %b want 1", in_ready);   else n_pass++;
    n_checks++; if (product !== 32'h0)  $display("FAIL abort_product: got %h want 0", product);     else n_pass++;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) $display("FAIL abort_lost_result: got %b want 0", seen); else n_pass++;
    issue(16'd100, 16'd200);
    wait_valid(lat);
    pop_exp(e);
    n_checks++; if (lat !== 17)          $display("FAIL abort_next_latency: got %0d want 17", lat);             else n_pass++;
    n_checks++; if (product !== e[31:0]) $display("FAIL abort_next_product: got %h want %h", product, e[31:0]); else n_pass++;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    int lat;
    int hold;
    logic [32:0] e;
    logic [15:0] x;
    logic [15:0] y;
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom_range(1, 65535));
      y = 16'($urandom_range(1, 65535));
      out_ready = 1'b0;
      issue(x, y);
      wait_valid(lat);
      hold = $urandom_range(0, 3);
      repeat (hold) @(negedge clk);
      pop_exp(e);
      n_checks++;
      if (lat !== 17 || product !== e[31:0] || ovf16 !== e[32])
        $display("FAIL rand%0d %h*%h: got lat=%0d p=%h o=%b want lat=17 p=%h o=%b", i, x, y, lat, product, ovf16, e[31:0], e[32]);
      else n_pass++;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_zero;
    int lat;
    logic [32:0] e;
    logic [15:0] xs [2];
    logic [15:0] ys [2];
    xs[0] = 16'h0000; ys[0] = 16'h1234;
    xs[1] = 16'h1234; ys[1] = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      out_ready = 1'b1;
      issue(xs[i], ys[i]);
      wait_valid(lat);
      pop_exp(e);
      n_checks++; if (lat !== ZERO_LAT)    $display("FAIL zero%0d_latency: got %0d want %0d", i, lat, ZERO_LAT);   else n_pass++;
      n_checks++; if (product !== e[31:0] || ovf16 !== e[32])
        $display("FAIL zero%0d_product: got %h/%b want %h/%b", i, product, ovf16, e[31:0], e[32]);
      else n_pass++;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 16'h0;
    b         = 16'h0;
    out_ready = 1'b0;
    test_reset;
    test_basic;
    test_max;
    test_backpressure;
    test_ignore_in_valid;
    test_reset_abort;
    test_random;
    test_zero;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
